// File: rtl/control_sequencer_if.sv
// Control bundle between the hardwired sequencer and the single-bus datapath.
// master = sequencer side, slave = datapath / IR / CON side.
interface control_sequencer_if;
    logic [31:0] IR;
    logic        CON_FF;
    logic        mem_ready;
    logic        stop;
    logic        Gra, Grb, Grc, Rin, Rout, BAout, Cout;
    logic [6:0]  dp_in;
    logic [2:0]  dp_out;
    logic        IncPC;
    logic [3:0]  alu_op;
    logic        Read, Write;
    logic        run;

    modport master (
        input  IR, CON_FF, mem_ready, stop,
        output Gra, Grb, Grc, Rin, Rout, BAout, Cout,
        output dp_in, dp_out, IncPC, alu_op, Read, Write, run
    );

    modport slave (
        output IR, CON_FF, mem_ready, stop,
        input  Gra, Grb, Grc, Rin, Rout, BAout, Cout,
        input  dp_in, dp_out, IncPC, alu_op, Read, Write, run
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired T-state control unit for the single-bus CPU datapath.
// Optional feature: define CTRL_BRANCH_EN to compile in the br sequence.
module control_sequencer (
    input  logic                clock,
    input  logic                reset,
    control_sequencer_if.master bus
);
    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT, S_STOP
    } state_t;

    typedef enum logic [2:0] {
        C_NOP, C_RR, C_IMM, C_LDI, C_LD, C_ST, C_BR, C_HALT
    } cls_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;

    state_t     state_q, state_d;
    logic [4:0] op_q, op_d;
    logic       t1_seen_q, t1_seen_d;
    cls_t       cls;
    logic [3:0] op_alu;
    state_t     boundary;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_RST;
            op_q      <= 5'd0;
            t1_seen_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            t1_seen_q <= t1_seen_d;
        end
    end

    always_comb begin
        cls    = C_NOP;
        op_alu = ALU_ADD;
        case (op_q)
            5'b00000: cls = C_LD;
            5'b00001: cls = C_LDI;
            5'b00010: cls = C_ST;
            5'b00011: begin cls = C_RR;  op_alu = ALU_ADD; end
            5'b00100: begin cls = C_RR;  op_alu = ALU_SUB; end
            5'b00101: begin cls = C_RR;  op_alu = ALU_AND; end
            5'b00110: begin cls = C_RR;  op_alu = ALU_OR;  end
            5'b01000: begin cls = C_IMM; op_alu = ALU_ADD; end
            5'b01001: begin cls = C_IMM; op_alu = ALU_AND; end
            5'b01010: begin cls = C_IMM; op_alu = ALU_OR;  end
`ifdef CTRL_BRANCH_EN
            5'b10010: cls = C_BR;
`else
            5'b10010: cls = C_NOP;
`endif
            5'b11011: cls = C_HALT;
            default:  cls = C_NOP;
        endcase
    end

    // Instruction boundary: stop is only honoured when heading for T0.
    assign boundary = bus.stop ? S_STOP : S_T0;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        t1_seen_d = 1'b0;
        bus.Gra = 1'b0; bus.Grb = 1'b0; bus.Grc = 1'b0;
        bus.Rin = 1'b0; bus.Rout = 1'b0; bus.BAout = 1'b0; bus.Cout = 1'b0;
        bus.dp_in  = 7'd0;
        bus.dp_out = 3'd0;
        bus.IncPC  = 1'b0;
        bus.alu_op = ALU_ADD;
        bus.Read   = 1'b0;
        bus.Write  = 1'b0;
        bus.run    = 1'b1;
        case (state_q)
            S_RST: begin
                bus.run = 1'b0;
                state_d = boundary;
            end
            S_STOP: state_d = bus.stop ? S_STOP : S_T0;
            S_T0: begin
                bus.dp_out[0] = 1'b1; bus.dp_in[2] = 1'b1;
                bus.IncPC = 1'b1;     bus.dp_in[5] = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                // PC update happens once even if the fetch read is stretched.
                t1_seen_d = 1'b1;
                bus.Read  = 1'b1;
                if (!t1_seen_q) begin
                    bus.dp_out[2] = 1'b1; bus.dp_in[0] = 1'b1;
                end
                if (bus.mem_ready) begin
                    bus.dp_in[3] = 1'b1;
                    state_d = S_T2;
                end
            end
            S_T2: begin
                bus.dp_out[1] = 1'b1; bus.dp_in[1] = 1'b1;
                op_d    = bus.IR[31:27];
                state_d = S_T3;
            end
            S_T3: begin
                state_d = S_T4;
                case (cls)
                    C_RR, C_IMM: begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.dp_in[4] = 1'b1; end
                    C_LDI, C_LD, C_ST: begin bus.Grb = 1'b1; bus.BAout = 1'b1; bus.dp_in[4] = 1'b1; end
                    C_BR: begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.dp_in[6] = 1'b1; end
                    C_HALT: state_d = S_HALT;
                    default: state_d = boundary;
                endcase
            end
            S_T4: begin
                state_d = S_T5;
                case (cls)
                    C_RR: begin bus.Grc = 1'b1; bus.Rout = 1'b1; bus.dp_in[5] = 1'b1; bus.alu_op = op_alu; end
                    C_IMM: begin bus.Cout = 1'b1; bus.dp_in[5] = 1'b1; bus.alu_op = op_alu; end
                    C_LDI, C_LD, C_ST: begin bus.Cout = 1'b1; bus.dp_in[5] = 1'b1; end
                    C_BR: begin bus.dp_out[0] = 1'b1; bus.dp_in[4] = 1'b1; end
                    default: state_d = boundary;
                endcase
            end
            S_T5: begin
                state_d = S_T6;
                case (cls)
                    C_RR, C_IMM, C_LDI: begin
                        bus.dp_out[2] = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
                        state_d = boundary;
                    end
                    C_LD, C_ST: begin bus.dp_out[2] = 1'b1; bus.dp_in[2] = 1'b1; end
                    C_BR: begin bus.Cout = 1'b1; bus.dp_in[5] = 1'b1; end
                    default: state_d = boundary;
                endcase
            end
            S_T6: begin
                state_d = S_T7;
                case (cls)
                    C_LD: begin
                        bus.Read = 1'b1;
                        if (bus.mem_ready) bus.dp_in[3] = 1'b1;
                        else               state_d = S_T6;
                    end
                    C_ST: begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.dp_in[3] = 1'b1; end
                    C_BR: begin
                        bus.dp_out[2] = 1'b1;
`ifdef CTRL_BRANCH_EN
                        bus.dp_in[0] = bus.CON_FF;
`endif
                        state_d = boundary;
                    end
                    default: state_d = boundary;
                endcase
            end
            S_T7: begin
                state_d = boundary;
                case (cls)
                    C_LD: begin bus.dp_out[1] = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                    C_ST: begin
                        bus.Write = 1'b1;
                        if (!bus.mem_ready) state_d = S_T7;
                    end
                    default: ;
                endcase
            end
            S_HALT: bus.run = 1'b0;
            default: begin
                bus.run = 1'b0;
                state_d = S_RST;
            end
        endcase
    end
endmodule
